// File: rtl/vscale_htif_host_bridge.sv
// vscale_htif_host_bridge
//   Host-side master for the core's HTIF PCR port. It polls to_host
//   periodically and forwards each nonzero value once to a host-side
//   valid/ready stream. Reading to_host clears it inside the CSR file. It
//   also writes host-supplied values to from_host. Only one PCR transaction
//   is outstanding at a time.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   htif_pcr_req_*         PCR request channel to the CSR file (valid/ready)
//   htif_pcr_resp_*        PCR response channel from the CSR file (valid/ready)
//   fromhost_*             host write stream into from_host (valid/ready)
//   tohost_*               captured to_host values out to the host (valid/ready)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | counting down to the next poll, accepting host writes
// S_POLL_REQ | read request for to_host presented, waiting for acceptance
// S_POLL_RESP| waiting for the to_host read data
// S_DELIVER  | nonzero to_host value offered to the host; polling paused
// S_WR_REQ   | write request for from_host presented
// S_WR_RESP  | waiting for the write response, which is discarded

module vscale_htif_host_bridge #(
    parameter int                          POLL_INTERVAL  = 16,
    parameter int                          CSR_ADDR_WIDTH = 12,
    parameter int                          HTIF_PCR_WIDTH = 64,
    parameter logic [CSR_ADDR_WIDTH-1:0]   TO_HOST_ADDR   = 12'h780,
    parameter logic [CSR_ADDR_WIDTH-1:0]   FROM_HOST_ADDR = 12'h781
) (
    input  logic                      clk,
    input  logic                      reset_n,
    output logic                      htif_pcr_req_valid,
    input  logic                      htif_pcr_req_ready,
    output logic                      htif_pcr_req_rw,
    output logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr,
    output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
    input  logic                      htif_pcr_resp_valid,
    output logic                      htif_pcr_resp_ready,
    input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data,
    input  logic                      fromhost_valid,
    output logic                      fromhost_ready,
    input  logic [HTIF_PCR_WIDTH-1:0] fromhost_data,
    output logic                      tohost_valid,
    input  logic                      tohost_ready,
    output logic [HTIF_PCR_WIDTH-1:0] tohost_data
);

    localparam int               CNT_W      = $clog2(POLL_INTERVAL + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(POLL_INTERVAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL_REQ,
        S_POLL_RESP,
        S_DELIVER,
        S_WR_REQ,
        S_WR_RESP
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          poll_cnt_q;
    logic [HTIF_PCR_WIDTH-1:0] wdata_q;
    logic [HTIF_PCR_WIDTH-1:0] tohost_q;
    // The state is IDLE while reset is held, but fromhost_ready must stay low
    // then. This flag is set on the first clock after release and keeps
    // reset_n out of the output logic.
    logic                      armed_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            poll_cnt_q <= CNT_RELOAD;
            wdata_q    <= '0;
            tohost_q   <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            // Staying in IDLE implies a nonzero count. Any other path reloads
            // the counter, so every entry into IDLE starts a full interval.
            if (state_q == S_IDLE && state_d == S_IDLE)
                poll_cnt_q <= poll_cnt_q - CNT_W'(1);
            else
                poll_cnt_q <= CNT_RELOAD;
            if (state_q == S_IDLE && state_d == S_WR_REQ)
                wdata_q <= fromhost_data;
            if (state_q == S_POLL_RESP && state_d == S_DELIVER)
                tohost_q <= htif_pcr_resp_data;
        end
    end

    always_comb begin
        state_d             = state_q;
        htif_pcr_req_valid  = 1'b0;
        htif_pcr_req_rw     = 1'b0;
        htif_pcr_req_addr   = '0;
        htif_pcr_req_data   = '0;
        htif_pcr_resp_ready = 1'b0;
        fromhost_ready      = 1'b0;
        tohost_valid        = 1'b0;
        tohost_data         = tohost_q;
        case (state_q)
            S_IDLE: begin
                fromhost_ready = armed_q;
                if (fromhost_valid && armed_q)
                    state_d = S_WR_REQ;
                else if (poll_cnt_q == '0)
                    state_d = S_POLL_REQ;
            end
            S_POLL_REQ: begin
                htif_pcr_req_valid = 1'b1;
                htif_pcr_req_addr  = TO_HOST_ADDR;
                if (htif_pcr_req_ready)
                    state_d = S_POLL_RESP;
            end
            S_POLL_RESP: begin
                htif_pcr_resp_ready = 1'b1;
                if (htif_pcr_resp_valid)
                    state_d = (|htif_pcr_resp_data) ? S_DELIVER : S_IDLE;
            end
            S_DELIVER: begin
                tohost_valid = 1'b1;
                if (tohost_ready)
                    state_d = S_IDLE;
            end
            S_WR_REQ: begin
                htif_pcr_req_valid = 1'b1;
                htif_pcr_req_rw    = 1'b1;
                htif_pcr_req_addr  = FROM_HOST_ADDR;
                htif_pcr_req_data  = wdata_q;
                if (htif_pcr_req_ready)
                    state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                htif_pcr_resp_ready = 1'b1;
                if (htif_pcr_resp_valid)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
